sum_frame_n_m: RTL and testbench

//  Streaming frame accumulator: sums frames of 1..M_MAX words of N bits from a valid/ready input stream.

---
 rtl/sum_frame_n_m.sv | 133 +++++++++++++
 tb/tb_sum_frame_n_m.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/sum_frame_n_m.sv
// Streaming frame accumulator: sums 1..M_MAX words per frame from a valid/ready stream
// and presents one widened sum per frame with an N-bit range-overflow flag.
module sum_frame_n_m #(
  parameter  int unsigned N     = 32,
  parameter  int unsigned M_MAX = 16,
  localparam int unsigned LW    = $clog2(M_MAX + 1),
  localparam int unsigned W     = N + $clog2(M_MAX)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [LW-1:0] len_i,
  input  logic          signed_i,
  input  logic [N-1:0]  data_i,
  input  logic          valid_i,
  output logic          ready_o,
  output logic [W-1:0]  sum_o,
  output logic          c_o,
  output logic          valid_o,
  input  logic          ready_i,
  output logic          fl_end
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [W-1:0]  acc, acc_nxt;
  logic [LW-1:0] cnt, cnt_nxt;
  logic [LW-1:0] len_q, len_nxt;
  logic          sgn_q, sgn_nxt;
  logic [W-1:0]  sum_nxt;
  logic          c_nxt;
  logic          valid_nxt;

  logic          beat_in;
  logic          beat_out;
  logic          start;
  logic [LW-1:0] len_eff;
  logic [LW-1:0] len_use;
  logic          sgn_use;
  logic [W-1:0]  ext_d;
  logic [W-1:0]  total;
  logic [LW-1:0] cnt_inc;
  logic          last;
  logic          ovf;

  // In HOLD the input only moves when the held sum retires in the same cycle.
  assign ready_o  = !rst_i && ((state != HOLD) || ready_i);
  assign fl_end   = valid_o && ready_i;
  assign beat_in  = valid_i && ready_o;
  assign beat_out = valid_o && ready_i;
  assign start    = beat_in && (state != ACC);

  // Frame parameters come from the ports on a first beat, from the latches otherwise.
  assign len_eff = ((len_i == '0) || (len_i > LW'(M_MAX))) ? LW'(M_MAX) : len_i;
  assign len_use = start ? len_eff : len_q;
  assign sgn_use = start ? signed_i : sgn_q;
  assign ext_d   = sgn_use ? {{(W-N){data_i[N-1]}}, data_i} : W'(data_i);
  assign total   = start ? ext_d : acc + ext_d;
  assign cnt_inc = start ? LW'(1) : cnt + LW'(1);
  assign last    = (cnt_inc == len_use);

  // Signed fits N bits when the top W-N+1 bits are all equal; unsigned when the top W-N are zero.
  always_comb begin
    ovf = 1'b0;
    if (sgn_use) begin
      ovf = !((&total[W-1:N-1]) || !(|total[W-1:N-1]));
    end else begin
      ovf = |total[W-1:N];
    end
  end

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    len_nxt   = len_q;
    sgn_nxt   = sgn_q;
    sum_nxt   = sum_o;
    c_nxt     = c_o;
    valid_nxt = valid_o;
    if (beat_in) begin
      acc_nxt = total;
      cnt_nxt = cnt_inc;
      len_nxt = len_use;
      sgn_nxt = sgn_use;
      if (last) begin
        state_nxt = HOLD;
        sum_nxt   = total;
        c_nxt     = ovf;
        valid_nxt = 1'b1;
      end else begin
        state_nxt = ACC;
        valid_nxt = 1'b0;
      end
    end else if (beat_out) begin
      state_nxt = IDLE;
      valid_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= IDLE;
      acc     <= '0;
      cnt     <= '0;
      len_q   <= '0;
      sgn_q   <= 1'b0;
      sum_o   <= '0;
      c_o     <= 1'b0;
      valid_o <= 1'b0;
    end else begin
      state   <= state_nxt;
      acc     <= acc_nxt;
      cnt     <= cnt_nxt;
      len_q   <= len_nxt;
      sgn_q   <= sgn_nxt;
      sum_o   <= sum_nxt;
      c_o     <= c_nxt;
      valid_o <= valid_nxt;
    end
  end

  a_valid_is_hold : assert property (@(posedge clk_i) disable iff (rst_i)
    valid_o == (state == HOLD));

  a_frozen_under_backpressure : assert property (@(posedge clk_i) disable iff (rst_i)
    (valid_o && !ready_i) |=> (valid_o && $stable(sum_o) && $stable(c_o)));

endmodule

// File: tb/tb_sum_frame_n_m.sv
// Scoreboard bench for sum_frame_n_m at N=8, M_MAX=4 with directed, hand-computed frames.
module tb_sum_frame_n_m;

  localparam int unsigned N     = 8;
  localparam int unsigned M_MAX = 4;
  localparam int unsigned LW    = $clog2(M_MAX + 1);
  localparam int unsigned W     = N + $clog2(M_MAX);

  logic          clk_i;
  logic          rst_i;
  logic [LW-1:0] len_i;
  logic          signed_i;
  logic [N-1:0]  data_i;
  logic          valid_i;
  logic          ready_o;
  logic [W-1:0]  sum_o;
  logic          c_o;
  logic          valid_o;
  logic          ready_i;
  logic          fl_end;

  int n_checks = 0;
  int n_fail   = 0;
  logic [W:0] exp_q[$];   // {c, sum}

  sum_frame_n_m #(.N(N), .M_MAX(M_MAX)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .len_i(len_i), .signed_i(signed_i),
    .data_i(data_i), .valid_i(valid_i), .ready_o(ready_o), .sum_o(sum_o),
    .c_o(c_o), .valid_o(valid_o), .ready_i(ready_i), .fl_end(fl_end)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push(input int sum, input logic c);
    logic [W-1:0] s;
    s = W'(sum);
    exp_q.push_back({c, s});
  endtask

  // One beat: drive at negedge, wait for acceptance, then check valid_o just after the edge.
  task automatic beat(input logic [7:0] d, input logic [LW-1:0] len, input logic sgn,
                      input logic exp_v, input string nm);
    int k;
    @(negedge clk_i);
    data_i = d; len_i = len; signed_i = sgn; valid_i = 1'b1;
    #1;
    k = 0;
    while (!ready_o && k < 50) begin
      @(negedge clk_i);
      #1;
      k++;
    end
    if (!ready_o) begin
      chk({nm, "_accept_timeout"}, 32'(ready_o), 32'd1);
      valid_i = 1'b0;
    end else begin
      @(posedge clk_i);
      #1;
      chk({nm, "_valid_after_beat"}, 32'(valid_o), 32'(exp_v));
    end
  endtask

  task automatic idle();
    @(negedge clk_i);
    valid_i = 1'b0;
  endtask

  task automatic drain(input string nm);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 50) begin
      @(negedge clk_i);
      k++;
    end
    chk({nm, "_drain"}, 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: samples just after the negedge, when the values for the next posedge are settled.
  initial begin
    logic [W:0] e;
    forever begin
      @(negedge clk_i);
      #2;
      if (!rst_i && valid_o && ready_i) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output: got sum 0x%0h with empty scoreboard at %0t", sum_o, $time);
        end else begin
          e = exp_q.pop_front();
          chk("out_sum", 32'(sum_o), 32'(e[W-1:0]));
          chk("out_c", 32'(c_o), 32'(e[W]));
          chk("out_fl_end", 32'(fl_end), 32'd1);
        end
      end
    end
  end

  initial begin
    rst_i = 1'b1; len_i = '0; signed_i = 1'b0; data_i = '0; valid_i = 1'b0; ready_i = 1'b1;
    @(negedge clk_i);
    #1;
    chk("rst_ready", 32'(ready_o), 32'd0);
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_sum", 32'(sum_o), 32'd0);
    chk("rst_c", 32'(c_o), 32'd0);
    chk("rst_fl_end", 32'(fl_end), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;

    // T1: unsigned 4-word frame, output one cycle after the last beat
    push(100, 1'b0);
    beat(8'd10, 3'd4, 1'b0, 1'b0, "t1_b0");
    beat(8'd20, 3'd4, 1'b0, 1'b0, "t1_b1");
    beat(8'd30, 3'd4, 1'b0, 1'b0, "t1_b2");
    beat(8'd40, 3'd4, 1'b0, 1'b1, "t1_b3");
    chk("t1_sum_latency", 32'(sum_o), 32'd100);
    idle();
    drain("t1");

    // T2: unsigned and signed overflow, back-to-back
    push(1020, 1'b1);
    push(10'h300, 1'b1);
    for (int i = 0; i < 4; i++) beat(8'hFF, 3'd4, 1'b0, 1'(i == 3), "t2_u");
    beat(8'h80, 3'd2, 1'b1, 1'b0, "t2_s0");
    beat(8'h80, 3'd2, 1'b1, 1'b1, "t2_s1");

    // T3: signed in range, then unsigned frame (mode latched per frame)
    push(10'h384, 1'b0);
    push(256, 1'b1);
    beat(8'h80, 3'd3, 1'b1, 1'b0, "t3_s0");
    beat(8'hFF, 3'd3, 1'b1, 1'b0, "t3_s1");
    beat(8'h05, 3'd3, 1'b1, 1'b1, "t3_s2");
    beat(8'hFF, 3'd2, 1'b0, 1'b0, "t3_u0");
    beat(8'h01, 3'd2, 1'b0, 1'b1, "t3_u1");
    idle();
    drain("t2_t3");

    // T4: backpressure in HOLD, then simultaneous beat out and beat in
    @(negedge clk_i);
    ready_i = 1'b0;
    push(7, 1'b0);
    push(3, 1'b0);
    beat(8'd3, 3'd2, 1'b0, 1'b0, "t4_b0");
    beat(8'd4, 3'd2, 1'b0, 1'b1, "t4_b1");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      if (i == 0) begin
        data_i = 8'd1; len_i = 3'd2; signed_i = 1'b0; valid_i = 1'b1;
      end
      #1;
      chk("t4_bp_valid", 32'(valid_o), 32'd1);
      chk("t4_bp_ready", 32'(ready_o), 32'd0);
      chk("t4_bp_sum", 32'(sum_o), 32'd7);
      chk("t4_bp_fl_end", 32'(fl_end), 32'd0);
    end
    @(negedge clk_i);
    ready_i = 1'b1;
    #1;
    chk("t4_release_ready", 32'(ready_o), 32'd1);
    @(posedge clk_i);
    #1;
    chk("t4_release_valid", 32'(valid_o), 32'd0);
    beat(8'd2, 3'd2, 1'b0, 1'b1, "t4_b3");
    idle();
    drain("t4");

    // T5: L=1, len 0 and over-range map to M_MAX, mid-frame len change ignored
    push(7, 1'b0);
    beat(8'd7, 3'd1, 1'b0, 1'b1, "t5_l1");
    chk("t5_l1_sum", 32'(sum_o), 32'd7);
    idle();
    drain("t5_l1");
    push(4, 1'b0);
    push(8, 1'b0);
    push(11, 1'b0);
    push(9, 1'b0);
    for (int i = 0; i < 4; i++) beat(8'd1, 3'd0, 1'b0, 1'(i == 3), "t5_len0");
    // 7 is the widest over-range value the 3-bit length port can carry
    for (int i = 0; i < 4; i++) beat(8'd2, 3'd7, 1'b0, 1'(i == 3), "t5_len7");
    beat(8'd5, 3'd2, 1'b0, 1'b0, "t5_mid0");
    beat(8'd6, 3'd4, 1'b0, 1'b1, "t5_mid1");
    beat(8'd9, 3'd1, 1'b0, 1'b1, "t5_after");
    idle();
    drain("t5");

    // T6: async reset mid-frame discards the partial frame
    push(256, 1'b1);
    beat(8'hFF, 3'd2, 1'b0, 1'b0, "t6_pre0");
    beat(8'h01, 3'd2, 1'b0, 1'b1, "t6_pre1");
    idle();
    drain("t6_pre");
    beat(8'd1, 3'd4, 1'b0, 1'b0, "t6_p0");
    beat(8'd2, 3'd4, 1'b0, 1'b0, "t6_p1");
    #3;
    rst_i = 1'b1;
    #1;
    chk("t6_rst_valid", 32'(valid_o), 32'd0);
    chk("t6_rst_sum", 32'(sum_o), 32'd0);
    chk("t6_rst_c", 32'(c_o), 32'd0);
    chk("t6_rst_ready", 32'(ready_o), 32'd0);
    repeat (2) @(negedge clk_i);
    valid_i = 1'b0;
    rst_i = 1'b0;
    push(10, 1'b0);
    for (int i = 0; i < 4; i++) beat(8'(i + 1), 3'd4, 1'b0, 1'(i == 3), "t6_post");
    idle();
    drain("t6");

    repeat (3) @(negedge clk_i);
    chk("final_scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
